// File: rtl/bp_profiler_pkg.sv
// bp_profiler_pkg
// Shared constants and helpers for the profiler counter bank. The host-side
// header generator uses the same helpers, so the read address map stays in one place.
//
// Read address map, in ascending word addresses:
//   CtrAddrShadow : num_events * words shadow counter words, LS word first
//   CtrAddrEpoch  : one word holding the interval epoch count
//   CtrAddrOvf    : ovf_words words of shadow overflow flags, LSB = channel 0
//   CtrAddrEnd    : first unmapped address, which is also the total word count
package bp_profiler_pkg;

  typedef enum logic [1:0] {
    CtrAddrShadow,
    CtrAddrEpoch,
    CtrAddrOvf,
    CtrAddrEnd
  } bp_profiler_ctr_addr_e;

  // Read-port words per counter.
  function automatic int unsigned calc_words(input int unsigned ctr_width,
                                             input int unsigned width);
    return ctr_width / width;
  endfunction

  // Read-port words needed to hold one overflow bit per channel.
  function automatic int unsigned calc_ovf_words(input int unsigned num_events,
                                                 input int unsigned width);
    return (num_events + width - 1) / width;
  endfunction

  // Base word address of each region of the read map.
  function automatic int unsigned ctr_addr_base(input bp_profiler_ctr_addr_e region,
                                                input int unsigned num_events,
                                                input int unsigned words,
                                                input int unsigned ovf_words);
    int unsigned base;
    base = 0;
    unique case (region)
      CtrAddrShadow: base = 0;
      CtrAddrEpoch:  base = num_events * words;
      CtrAddrOvf:    base = num_events * words + 1;
      CtrAddrEnd:    base = num_events * words + 1 + ovf_words;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/bp_profiler_sat_counter.sv
// bp_profiler_sat_counter
// One live event counter. It saturates at all-ones and keeps a sticky
// overflow flag. It can optionally restart when a snapshot is taken.
//
// Ports:
//   clk_i   - clock
//   reset_i - synchronous active-high reset
//   clear_i - synchronous clear (freeze); overrides snapshot and increment
//   snap_i  - a snapshot is being taken this cycle
//   inc_i   - add one this cycle (already gated by the global enable)
//   cnt_o   - registered count
//   ovf_o   - sticky overflow: an increment arrived while the count was saturated
module bp_profiler_sat_counter #(
  parameter int unsigned ctr_width_p     = 64,
  parameter bit          clear_on_snap_p = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   clear_i,
  input  logic                   snap_i,
  input  logic                   inc_i,
  output logic [ctr_width_p-1:0] cnt_o,
  output logic                   ovf_o
);

  logic [ctr_width_p-1:0] cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (clear_on_snap_p && snap_i) begin
      // The shadow takes the old value, so this cycle's event starts the new
      // interval. No event is lost and none is counted twice.
      cnt_d = ctr_width_p'(inc_i);
      ovf_d = 1'b0;
    end else if (inc_i) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ctr_width_p'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/bp_profiler_counter_bank.sv
// bp_profiler_counter_bank
// A bank of saturating event counters. Snapshots are atomic and go into
// shadow registers. They are taken on request or by a periodic interval
// timer, which also advances an epoch count. The host reads the shadows
// through a registered, word-addressed read port and never sees the live
// counters.
//
// Ports:
//   clk_i       - clock
//   reset_i     - synchronous active-high reset of all state
//   freeze_i    - clears live counters, live overflow, timer and epoch; keeps shadows
//   en_i        - global count enable; also gates the interval timer
//   event_i     - per-channel increment strobes
//   snap_i      - software snapshot request
//   interval_i  - auto-snapshot period in enabled cycles; 0 disables
//   snap_done_o - pulses the cycle after a snapshot is taken
//   rd_v_i      - read request
//   rd_addr_i   - read word address (see bp_profiler_pkg for the map)
//   rd_v_o      - read data valid, one cycle after rd_v_i
//   rd_data_o   - read data, held while no read is issued
module bp_profiler_counter_bank
  import bp_profiler_pkg::*;
#(
  parameter int unsigned num_events_p     = 64,
  parameter int unsigned ctr_width_p      = 64,
  parameter int unsigned width_p          = 32,
  parameter int unsigned interval_width_p = 32,
  parameter bit          clear_on_snap_p  = 1'b0,
  localparam int unsigned words_lp         = calc_words(ctr_width_p, width_p),
  localparam int unsigned ovf_words_lp     = calc_ovf_words(num_events_p, width_p),
  localparam int unsigned rd_words_lp      = ctr_addr_base(CtrAddrEnd, num_events_p, words_lp,
                                                           ovf_words_lp),
  localparam int unsigned rd_addr_width_lp = $clog2(rd_words_lp)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        freeze_i,
  input  logic                        en_i,
  input  logic [num_events_p-1:0]     event_i,
  input  logic                        snap_i,
  input  logic [interval_width_p-1:0] interval_i,
  output logic                        snap_done_o,
  input  logic                        rd_v_i,
  input  logic [rd_addr_width_lp-1:0] rd_addr_i,
  output logic                        rd_v_o,
  output logic [width_p-1:0]          rd_data_o
);

  localparam int unsigned epoch_idx_lp = ctr_addr_base(CtrAddrEpoch, num_events_p, words_lp,
                                                       ovf_words_lp);
  localparam int unsigned ovf_idx_lp   = ctr_addr_base(CtrAddrOvf, num_events_p, words_lp,
                                                       ovf_words_lp);
  localparam int unsigned ovf_bits_lp  = ovf_words_lp * width_p;

  logic [num_events_p-1:0][ctr_width_p-1:0] live_cnt;
  logic [num_events_p-1:0][ctr_width_p-1:0] shadow_q;
  logic [num_events_p-1:0]                  live_ovf;
  logic [num_events_p-1:0]                  shadow_ovf_q;

  logic [interval_width_p-1:0] timer_q, timer_d;
  logic [interval_width_p-1:0] epoch_q, epoch_d;
  logic                        auto_snap;
  logic                        snap;
  logic                        snap_done_q;

  logic                 rd_v_q;
  logic [width_p-1:0]   rd_data_q;
  logic [width_p-1:0]   rd_word;
  logic [ovf_bits_lp-1:0] ovf_pad;
  logic [width_p-1:0]   rd_words [rd_words_lp];

  // ---------------------------------------------------------------------------
  // Interval timer and epoch
  // ---------------------------------------------------------------------------
  always_comb begin
    timer_d   = timer_q;
    epoch_d   = epoch_q;
    auto_snap = 1'b0;
    if (freeze_i) begin
      timer_d = '0;
      epoch_d = '0;
    end else if (interval_i == '0) begin
      timer_d = '0;
    end else if (timer_q >= interval_i) begin
      // The period shrank below the elapsed count. Restart without snapping.
      timer_d = '0;
    end else if (en_i) begin
      if (timer_q == interval_i - interval_width_p'(1)) begin
        auto_snap = 1'b1;
        timer_d   = '0;
        epoch_d   = epoch_q + interval_width_p'(1);
      end else begin
        timer_d = timer_q + interval_width_p'(1);
      end
    end
  end

  // A software request and an auto-snap in the same cycle merge into one
  // snapshot. Freeze suppresses both.
  assign snap = ~freeze_i & (snap_i | auto_snap);

  // ---------------------------------------------------------------------------
  // Live counters
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < num_events_p; i++) begin : g_ctr
    bp_profiler_sat_counter #(
      .ctr_width_p     (ctr_width_p),
      .clear_on_snap_p (clear_on_snap_p)
    ) u_ctr (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (freeze_i),
      .snap_i  (snap),
      .inc_i   (en_i & event_i[i]),
      .cnt_o   (live_cnt[i]),
      .ovf_o   (live_ovf[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Read word map
  // ---------------------------------------------------------------------------
  for (genvar e = 0; e < num_events_p; e++) begin : g_shadow_words
    for (genvar w = 0; w < words_lp; w++) begin : g_word
      assign rd_words[e*words_lp + w] = shadow_q[e][w*width_p +: width_p];
    end
  end

  assign rd_words[epoch_idx_lp] = width_p'(epoch_q);

  assign ovf_pad = ovf_bits_lp'(shadow_ovf_q);
  for (genvar o = 0; o < ovf_words_lp; o++) begin : g_ovf_words
    assign rd_words[ovf_idx_lp + o] = ovf_pad[o*width_p +: width_p];
  end

  // Addresses past the map return 0.
  always_comb begin
    rd_word = '0;
    for (int unsigned k = 0; k < rd_words_lp; k++) begin
      if (rd_addr_i == rd_addr_width_lp'(k)) begin
        rd_word = rd_words[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      timer_q      <= '0;
      epoch_q      <= '0;
      snap_done_q  <= 1'b0;
      shadow_q     <= '0;
      shadow_ovf_q <= '0;
      rd_v_q       <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      timer_q     <= timer_d;
      epoch_q     <= epoch_d;
      snap_done_q <= snap;
      // The shadows take the live values registered before this cycle's increment.
      if (snap) begin
        shadow_q     <= live_cnt;
        shadow_ovf_q <= live_ovf;
      end
      rd_v_q <= rd_v_i;
      // A read in a snapshot cycle sees the old shadow, because rd_word is
      // built from the registered shadow.
      if (rd_v_i) begin
        rd_data_q <= rd_word;
      end
    end
  end

  assign snap_done_o = snap_done_q;
  assign rd_v_o      = rd_v_q;
  assign rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_bp_profiler_counter_bank.sv
// Bench for bp_profiler_counter_bank. Two instances share the stimulus: dut0
// keeps counting across snapshots and dut1 restarts its counters on each
// snapshot. Expected read words and snap_done cycles go into queues, and a
// negedge monitor compares them as the DUT presents them.
module tb_bp_profiler_counter_bank;

  logic       clk = 1'b0;
  logic       reset, freeze, en, snap, rd_v;
  logic [3:0] evt;
  logic [7:0] interval;
  logic [3:0] rd_addr;

  logic       snap_done0, snap_done1, rd_v_o0, rd_v_o1;
  logic [3:0] rd_data0, rd_data1;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  data;
    string       name;
  } rd_exp_t;

  rd_exp_t     q0[$];
  rd_exp_t     q1[$];
  int unsigned sd0[$];
  int unsigned sd1[$];

  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bp_profiler_counter_bank #(
    .num_events_p     (4),
    .ctr_width_p      (8),
    .width_p          (4),
    .interval_width_p (8),
    .clear_on_snap_p  (1'b0)
  ) dut0 (
    .clk_i       (clk),
    .reset_i     (reset),
    .freeze_i    (freeze),
    .en_i        (en),
    .event_i     (evt),
    .snap_i      (snap),
    .interval_i  (interval),
    .snap_done_o (snap_done0),
    .rd_v_i      (rd_v),
    .rd_addr_i   (rd_addr),
    .rd_v_o      (rd_v_o0),
    .rd_data_o   (rd_data0)
  );

  bp_profiler_counter_bank #(
    .num_events_p     (4),
    .ctr_width_p      (8),
    .width_p          (4),
    .interval_width_p (8),
    .clear_on_snap_p  (1'b1)
  ) dut1 (
    .clk_i       (clk),
    .reset_i     (reset),
    .freeze_i    (freeze),
    .en_i        (en),
    .event_i     (evt),
    .snap_i      (snap),
    .interval_i  (interval),
    .snap_done_o (snap_done1),
    .rd_v_i      (rd_v),
    .rd_addr_i   (rd_addr),
    .rd_v_o      (rd_v_o1),
    .rd_data_o   (rd_data1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Single-cycle read; e0/e1 are the expected words from dut0/dut1.
  task automatic rd(input logic [3:0] a, input logic [3:0] e0, input logic [3:0] e1,
                    input string nm);
    rd_exp_t x;
    x.cyc  = cyc;
    x.name = nm;
    x.data = e0;
    q0.push_back(x);
    x.data = e1;
    q1.push_back(x);
    rd_v    = 1'b1;
    rd_addr = a;
    step(1);
    rd_v = 1'b0;
  endtask

  task automatic expect_sd(input int unsigned c);
    sd0.push_back(c);
    sd1.push_back(c);
  endtask

  task automatic do_snap();
    snap = 1'b1;
    expect_sd(cyc + 1);
    step(1);
    snap = 1'b0;
  endtask

  task automatic freeze_pulse();
    freeze = 1'b1;
    step(1);
    freeze = 1'b0;
  endtask

  // Monitor: compares read data, read latency and snap_done timing.
  always @(negedge clk) begin
    rd_exp_t     e;
    int unsigned s;
    if (rd_v_o0) begin
      if (q0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut0 unexpected rd_v_o at cycle %0d: got 1, expected 0", cyc);
      end else begin
        e = q0.pop_front();
        chk({"dut0 ", e.name}, 32'(rd_data0), 32'(e.data));
        chk({"dut0 latency ", e.name}, cyc, e.cyc + 1);
      end
    end
    if (rd_v_o1) begin
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut1 unexpected rd_v_o at cycle %0d: got 1, expected 0", cyc);
      end else begin
        e = q1.pop_front();
        chk({"dut1 ", e.name}, 32'(rd_data1), 32'(e.data));
        chk({"dut1 latency ", e.name}, cyc, e.cyc + 1);
      end
    end
    if (snap_done0) begin
      if (sd0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut0 unexpected snap_done at cycle %0d: got 1, expected 0", cyc);
      end else begin
        s = sd0.pop_front();
        chk("dut0 snap_done cycle", cyc, s);
      end
    end
    if (snap_done1) begin
      if (sd1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut1 unexpected snap_done at cycle %0d: got 1, expected 0", cyc);
      end else begin
        s = sd1.pop_front();
        chk("dut1 snap_done cycle", cyc, s);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned k;
    reset = 1'b1; freeze = 1'b0; en = 1'b0; evt = '0; snap = 1'b0;
    interval = '0; rd_v = 1'b0; rd_addr = '0;

    // Reset state
    step(2);
    @(negedge clk);
    chk("reset rd_v_o dut0", 32'(rd_v_o0), 0);
    chk("reset rd_v_o dut1", 32'(rd_v_o1), 0);
    chk("reset rd_data dut0", 32'(rd_data0), 0);
    chk("reset snap_done dut0", 32'(snap_done0), 0);
    step(1);
    reset = 1'b0;
    for (int a = 0; a < 10; a++) rd(4'(a), 4'h0, 4'h0, "reset read");

    // 1: counting and read ordering
    en = 1'b1; evt = 4'b0101;
    step(10);
    evt = '0;
    do_snap();
    rd(4'd0, 4'hA, 4'hA, "t1 ch0 lo");
    rd(4'd1, 4'h0, 4'h0, "t1 ch0 hi");
    rd(4'd2, 4'h0, 4'h0, "t1 ch1 lo");
    rd(4'd3, 4'h0, 4'h0, "t1 ch1 hi");
    rd(4'd4, 4'hA, 4'hA, "t1 ch2 lo");
    rd(4'd8, 4'h0, 4'h0, "t1 epoch");
    rd(4'd9, 4'h0, 4'h0, "t1 ovf");
    rd(4'd10, 4'h0, 4'h0, "t1 unmapped 10");
    rd(4'd15, 4'h0, 4'h0, "t1 unmapped 15");
    rd(4'd4, 4'hA, 4'hA, "t1 ch2 lo again");
    step(1);
    @(negedge clk);
    chk("t1 rd_data hold", 32'(rd_data0), 32'h0000000A);

    // 2: saturation boundary and sticky overflow
    freeze_pulse();
    evt = 4'b0010;
    step(255);
    evt = '0;
    do_snap();
    rd(4'd2, 4'hF, 4'hF, "t2 ch1 lo at max");
    rd(4'd3, 4'hF, 4'hF, "t2 ch1 hi at max");
    rd(4'd9, 4'h0, 4'h0, "t2 ovf clear at max");
    evt = 4'b0010;
    step(1);
    evt = '0;
    do_snap();
    rd(4'd2, 4'hF, 4'h1, "t2 ch1 lo saturated");
    rd(4'd3, 4'hF, 4'h0, "t2 ch1 hi saturated");
    rd(4'd9, 4'h2, 4'h0, "t2 ovf set");
    freeze_pulse();
    rd(4'd9, 4'h2, 4'h0, "t2 shadow ovf survives freeze");
    do_snap();
    rd(4'd9, 4'h0, 4'h0, "t2 ovf after freeze+snap");
    rd(4'd2, 4'h0, 4'h0, "t2 ch1 after freeze+snap");

    // 3: interval mode
    freeze_pulse();
    interval = 8'd5; evt = 4'b0001; en = 1'b1;
    k = cyc;
    expect_sd(k + 5); expect_sd(k + 10); expect_sd(k + 15);
    step(5);
    rd(4'd8, 4'h1, 4'h1, "t3 epoch 1");
    step(4);
    rd(4'd8, 4'h2, 4'h2, "t3 epoch 2");
    rd(4'd0, 4'h9, 4'h5, "t3 ch0 snap 2");
    step(2);
    rd(4'd8, 4'h2, 4'h2, "t3 read in snap cycle");
    rd(4'd8, 4'h3, 4'h3, "t3 epoch 3");
    rd(4'd0, 4'hE, 4'h5, "t3 ch0 snap 3");
    en = 1'b0; evt = '0; interval = '0;

    // 4: software snap collides with auto-snap
    freeze_pulse();
    interval = 8'd4; evt = 4'b0001; en = 1'b1;
    k = cyc;
    expect_sd(k + 4); expect_sd(k + 8);
    step(3);
    snap = 1'b1;
    step(1);
    snap = 1'b0;
    step(4);
    en = 1'b0; evt = '0; interval = '0;
    rd(4'd8, 4'h2, 4'h2, "t4 epoch single step");
    rd(4'd0, 4'h7, 4'h4, "t4 ch0 total");

    // 5: en gating of counters and timer
    freeze_pulse();
    interval = 8'd4; evt = 4'hF;
    k = cyc;
    expect_sd(k + 7); expect_sd(k + 15);
    for (int i = 0; i < 20; i++) begin
      en = (i % 2 == 0);
      step(1);
    end
    en = 1'b0; evt = '0; interval = '0;
    do_snap();
    rd(4'd0, 4'hA, 4'h3, "t5 ch0");
    rd(4'd2, 4'hA, 4'h3, "t5 ch1");
    rd(4'd4, 4'hA, 4'h3, "t5 ch2");
    rd(4'd6, 4'hA, 4'h3, "t5 ch3");
    rd(4'd1, 4'h0, 4'h0, "t5 ch0 hi");
    rd(4'd8, 4'h2, 4'h2, "t5 epoch");

    // 5b: interval shrinks below the elapsed timer count
    freeze_pulse();
    interval = 8'd8; en = 1'b1; evt = '0;
    k = cyc;
    step(5);
    interval = 8'd3;
    expect_sd(k + 9);
    step(4);
    en = 1'b0; interval = '0;
    rd(4'd8, 4'h1, 4'h1, "t5b epoch after shrink");

    // 6: reset mid-operation
    en = 1'b1; evt = 4'hF;
    step(5);
    evt = '0;
    do_snap();
    evt = 4'hF;
    reset = 1'b1; rd_v = 1'b1; rd_addr = 4'd0;
    step(1);
    reset = 1'b0; rd_v = 1'b0; evt = '0;
    @(negedge clk);
    chk("t6 rd_v_o after reset dut0", 32'(rd_v_o0), 0);
    chk("t6 rd_v_o after reset dut1", 32'(rd_v_o1), 0);
    chk("t6 rd_data after reset dut0", 32'(rd_data0), 0);
    rd(4'd0, 4'h0, 4'h0, "t6 ch0 after reset");
    rd(4'd4, 4'h0, 4'h0, "t6 ch2 after reset");
    rd(4'd8, 4'h0, 4'h0, "t6 epoch after reset");
    rd(4'd9, 4'h0, 4'h0, "t6 ovf after reset");

    // 6b: freeze concurrent with snap_i
    evt = 4'hF;
    step(3);
    evt = '0;
    do_snap();
    evt = 4'hF;
    step(2);
    freeze = 1'b1; snap = 1'b1;
    step(1);
    freeze = 1'b0; snap = 1'b0; evt = '0;
    rd(4'd0, 4'h3, 4'h3, "t6 shadow kept over freeze");
    evt = 4'hF;
    step(2);
    evt = '0;
    do_snap();
    rd(4'd0, 4'h2, 4'h2, "t6 ch0 restart after freeze");
    rd(4'd6, 4'h2, 4'h2, "t6 ch3 restart after freeze");
    rd(4'd9, 4'h0, 4'h0, "t6 ovf after freeze");

    step(3);
    chk("dut0 reads outstanding", 32'(q0.size()), 0);
    chk("dut1 reads outstanding", 32'(q1.size()), 0);
    chk("dut0 snap_done outstanding", 32'(sd0.size()), 0);
    chk("dut1 snap_done outstanding", 32'(sd1.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_profiler_counter_bank.md
Name: bp_profiler_counter_bank

Overview:
Parametrised bank of saturating event counters. It generalises the fixed 65-counter commit profiler output to N channels of arbitrary counter width. It adds atomic shadow snapshots, periodic interval sampling with an epoch count, sticky overflow flags, and a registered word-addressed read port. It sits beside the core profiler. The stall-reason one-hots and metric strobes feed event_i, and the host shell reads results through rd_*.

Parameters:
- num_events_p, 64, number of event channels / counters.
- ctr_width_p, 64, counter width in bits; must be a multiple of width_p.
- width_p, 32, read-port word width.
- interval_width_p, 32, width of the interval timer and the epoch counter.
- clear_on_snap_p, 0, when 1 every snapshot also restarts the live counters.
- Derived: words_lp = ctr_width_p/width_p.
- Derived: ovf_words_lp = ceil(num_events_p/width_p).
- Derived: rd_addr_width_lp = clog2(num_events_p*words_lp + 1 + ovf_words_lp).

Ports:
- clk_i, in, 1, clock.
- reset_i, in, 1, synchronous active-high reset.
- freeze_i, in, 1, synchronous clear of all live state; held high while the core is frozen.
- en_i, in, 1, global count enable; also gates the interval timer.
- event_i, in, num_events_p, per-channel increment strobe; +1 per cycle when high.
- snap_i, in, 1, software snapshot request (single-cycle pulse).
- interval_i, in, interval_width_p, auto-snapshot period in enabled cycles; 0 disables.
- snap_done_o, out, 1, one-cycle pulse the cycle after any snapshot is taken.
- rd_v_i, in, 1, read request.
- rd_addr_i, in, rd_addr_width_lp, read word address.
- rd_v_o, out, 1, read data valid.
- rd_data_o, out, width_p, read data.

Behaviour:
- Reset: all live counters, shadow counters, overflow flags, shadow overflow flags, timer and epoch go to 0. rd_v_o=0, rd_data_o=0, snap_done_o=0.
- Priority per cycle: reset_i > freeze_i > snapshot > increment.
- freeze_i=1: clears live counters, live overflow flags, timer and epoch. Shadows are kept. No increment, no auto-snap.
- Increment: if en_i & event_i[i], then live[i]++.
  - If live[i] is already at 2^ctr_width_p-1, it holds (saturates) and ovf[i] is set.
  - ovf[i] is sticky until reset or freeze.
- Auto snapshot: only when interval_i!=0 and en_i. The timer counts enabled cycles.
  - When timer==interval_i-1, an auto-snap fires, timer goes to 0 and epoch++ (epoch wraps modulo 2^interval_width_p).
  - If interval_i changes to a value <= timer, the timer resets to 0 with no snap that cycle.
- Snapshot (snap_i | auto-snap): shadow[i] <= live[i] and shadow_ovf <= ovf, using the registered values from before this cycle's increment.
  - snap_i and an auto-snap in the same cycle produce one snapshot. epoch increments once.
  - With clear_on_snap_p=1: live[i] <= (en_i & event_i[i]) and ovf is cleared, so no event is lost or double counted.
  - With clear_on_snap_p=0: live counting continues normally.
  - snap_done_o is asserted exactly 1 cycle later.
- Read path: latency 1. rd_v_o = registered rd_v_i, and rd_data_o is registered. When rd_v_i=0, rd_data_o holds its value.
- Read address map:
  - a < num_events_p*words_lp: shadow[a/words_lp] word (a%words_lp), word 0 = least significant.
  - a == num_events_p*words_lp: epoch, zero-extended or truncated to width_p.
  - the next ovf_words_lp addresses: shadow_ovf bits, LSB = channel 0.
  - any other address: returns 0.
- Reads never see live counters, so multi-word values are atomic per snapshot.
- A read in the same cycle as a snapshot returns the pre-snapshot shadow.

Decomposition:
- bp_profiler_pkg: add a bp_profiler_ctr_addr_e-style base-offset function and the derived word-count constants (words_lp, ovf_words_lp) so the host software header generator shares them.
- One sub-module, bp_profiler_sat_counter: ctr_width_p saturating counter with clear, load-on-snap, increment and sticky overflow. It is instantiated num_events_p times in a generate loop.
- The bank top holds the timer/epoch, the shadows and the read mux.

Test Plan (num_events_p=4, ctr_width_p=8, width_p=4, clear_on_snap_p=0 unless stated):
1. Counting and read ordering: after reset, en_i=1, event_i=4'b0101 for 10 cycles, then snap_i. Read addr 0 and 1 → 4'hA, 4'h0. Addr 2 and 3 → 0. Addr 4 → 4'hA. rd_v_o is asserted one cycle after each rd_v_i.
2. Saturation: event_i[1]=1 for 300 cycles, then snap. Addr 2,3 → 4'hF,4'hF. Addr 9 (ovf word) → 4'b0010. freeze_i then clears live ovf, but the shadow still reads 4'b0010 until the next snap.
3. Interval mode: interval_i=5, event_i[0]=1 constant, en_i=1. snap_done_o pulses every 5 cycles and epoch (addr 8) reads 1,2,3. With clear_on_snap_p=1, each snapshot of channel 0 reads 5.
4. Collision: snap_i coincides with an auto-snap → a single snap_done_o pulse and epoch +1 only. Under clear_on_snap_p=1 with event_i[0]=1 that cycle, the next snapshot still totals exactly interval_i.
5. en_i gating: toggle en_i every other cycle for 20 cycles with event_i=4'hF. All counters read 10, and the interval_i=4 timer fires only after 4 enabled cycles.
6. Reset/freeze mid-operation: assert reset_i during counting → all reads return 0 and rd_v_o=0 next cycle. Assert freeze_i for 1 cycle concurrently with snap_i → the snapshot is suppressed, no snap_done_o, and live counters restart from 0.
